// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// PC increment and next-PC select codes.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2
    } pc_sel_e;

    localparam int PC_STEP = 4;

    // Clears the two byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage : pc_seq_pkg

// File: rtl/next_pc_sel.sv
// Combinational next-PC choice: jump over taken branch over sequential,
// with target word alignment and modulo-2^PC_W increment.
module next_pc_sel
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic            branch,
    input  logic            alu_zero,
    input  logic            jump,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] next_pc,
    output pc_sel_e         sel
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    always_comb begin
        sel     = SEL_SEQ;
        // The adder is exactly PC_W bits wide, so the top word wraps to zero.
        next_pc = pc + PC_W'(PC_STEP);
        if (jump) begin
            sel     = SEL_JMP;
            next_pc = jump_target & ALIGN_MASK;
        end else if (branch && alu_zero) begin
            sel     = SEL_BR;
            next_pc = branch_target & ALIGN_MASK;
        end
    end

endmodule : next_pc_sel

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: IDLE -> FETCH (imem handshake) -> EXEC (wait for
// exec_done) -> FETCH. Optional taken-branch counter under PC_SEQ_BRANCH_STATS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_ready,
    input  logic            exec_done,
    input  logic            branch,
    input  logic            alu_zero,
    input  logic            jump,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic            instr_valid,
    output logic [1:0]      seq_state
`ifdef PC_SEQ_BRANCH_STATS_EN
    ,
    output logic [15:0]     taken_count
`endif
);

    seq_state_e      state_q;
    logic [PC_W-1:0] pc_q;
    logic            imem_req_q;
    logic            instr_valid_q;

    logic [PC_W-1:0] next_pc;
    pc_sel_e         sel;

    next_pc_sel #(
        .PC_W (PC_W)
    ) u_next_pc_sel (
        .pc            (pc_q),
        .branch        (branch),
        .alu_zero      (alu_zero),
        .jump          (jump),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .next_pc       (next_pc),
        .sel           (sel)
    );

    // imem_req is a registered Moore output: high exactly while state_q is FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        state_q       <= EXEC;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        pc_q       <= next_pc;
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign imem_req    = imem_req_q;
    assign instr_valid = instr_valid_q;
    assign seq_state   = state_q;

`ifdef PC_SEQ_BRANCH_STATS_EN
    logic [15:0] taken_count_q;
    logic [15:0] taken_count_d;

    always_comb begin
        taken_count_d = taken_count_q;
        if (state_q == EXEC && exec_done && sel == SEL_BR && taken_count_q != 16'hFFFF) begin
            taken_count_d = taken_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_count_q <= 16'd0;
        end else begin
            taken_count_q <= taken_count_d;
        end
    end

    assign taken_count = taken_count_q;
`else
    logic unused_sel;
    assign unused_sel = ^sel;
`endif

endmodule : pc_sequencer
